// File: rtl/lvds_rx_ctl.sv
// LVDS target-link receive controller: nibble pairing, frame parsing,
// CRC-8 check, payload streaming, good/bad counters and stall watchdog.
module lvds_rx_ctl #(
  parameter logic [7:0] ADDR    = 8'h01,
  parameter int         TIMEOUT = 64,
  parameter int         CW      = 16
) (
  input  logic          c,
  input  logic          rn,
  input  logic          ni_valid,
  input  logic [3:0]    ni,
  input  logic          ni_last,
  output logic          o_valid,
  output logic [7:0]    o_data,
  output logic          o_sop,
  output logic          o_end,
  output logic          o_ok,
  output logic [CW-1:0] cnt_good,
  output logic [CW-1:0] cnt_bad,
  output logic          busy
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN, S_DATA, S_CRC, S_DISC
  } state_t;

  state_t        state, state_n;
  logic          phase, phase_n;
  logic [3:0]    hi, hi_n;
  logic [7:0]    crc, crc_n;
  logic [7:0]    left, left_n;
  logic          emitted, emitted_n;
  logic [WW-1:0] wd, wd_n;
  logic          valid_n, sop_n, end_n, ok_n;
  logic [7:0]    data_n;
  logic          inc_good, inc_bad;
  logic [7:0]    byte_w;
  logic          done, tmo, in_frame;

  function automatic logic [7:0] crc8(input logic [7:0] cr,
                                      input logic [7:0] d);
    logic [7:0] x;
    x = cr ^ d;
    for (int i = 0; i < 8; i++)
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  assign byte_w = {hi, ni};
  assign done   = ni_valid & phase;
  assign tmo    = !ni_valid && (state != S_IDLE) &&
                  (wd == WW'(TIMEOUT - 1));

  always_comb begin
    state_n   = state;
    phase_n   = ni_valid ? ~phase : phase;
    hi_n      = (ni_valid && !phase) ? ni : hi;
    crc_n     = crc;
    left_n    = left;
    emitted_n = emitted;
    wd_n      = (ni_valid || state == S_IDLE) ? '0 : wd + 1'b1;
    valid_n   = 1'b0;
    data_n    = o_data;
    sop_n     = 1'b0;
    end_n     = 1'b0;
    ok_n      = 1'b0;
    inc_good  = 1'b0;
    inc_bad   = 1'b0;
    in_frame  = 1'b0;
    unique case (state)
      S_IDLE: begin
        phase_n   = 1'b0;
        crc_n     = 8'h00;
        emitted_n = 1'b0;
        if (ni_valid) begin
          hi_n = ni;
          if (ni_last) inc_bad = 1'b1;
          else begin
            state_n = S_HDR;
            phase_n = 1'b1;
          end
        end
      end
      S_HDR: begin
        in_frame = 1'b1;
        if (done && !ni_last) begin
          crc_n   = crc8(crc, byte_w);
          state_n = (byte_w == ADDR || byte_w == 8'hFF) ? S_LEN : S_DISC;
        end
      end
      S_LEN: begin
        in_frame = 1'b1;
        if (done && !ni_last) begin
          crc_n = crc8(crc, byte_w);
          if (byte_w == 8'h00) begin
            inc_bad = 1'b1;
            state_n = S_DISC;
          end else begin
            left_n  = byte_w;
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_frame = 1'b1;
        if (done && !ni_last) begin
          crc_n     = crc8(crc, byte_w);
          valid_n   = 1'b1;
          data_n    = byte_w;
          sop_n     = !emitted;
          emitted_n = 1'b1;
          left_n    = left - 8'd1;
          if (left == 8'd1) state_n = S_CRC;
        end
      end
      S_CRC: begin
        in_frame = !done;
        if (done) begin
          end_n    = 1'b1;
          ok_n     = ni_last && (byte_w == crc);
          inc_good = ok_n;
          inc_bad  = !ok_n;
          state_n  = ni_last ? S_IDLE : S_DISC;
        end
      end
      S_DISC: begin
        if ((ni_valid && ni_last) || tmo) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // early ni_last or stall inside a live frame aborts it
    if (in_frame && ((ni_valid && ni_last) || tmo)) begin
      state_n  = S_IDLE;
      valid_n  = 1'b0;
      sop_n    = 1'b0;
      end_n    = emitted;
      ok_n     = 1'b0;
      inc_good = 1'b0;
      inc_bad  = 1'b1;
    end
  end

  always_ff @(posedge c) begin
    if (!rn) begin
      state    <= S_IDLE;
      phase    <= 1'b0;
      hi       <= 4'h0;
      crc      <= 8'h00;
      left     <= 8'h00;
      emitted  <= 1'b0;
      wd       <= '0;
      o_valid  <= 1'b0;
      o_data   <= 8'h00;
      o_sop    <= 1'b0;
      o_end    <= 1'b0;
      o_ok     <= 1'b0;
      busy     <= 1'b0;
      cnt_good <= '0;
      cnt_bad  <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      hi      <= hi_n;
      crc     <= crc_n;
      left    <= left_n;
      emitted <= emitted_n;
      wd      <= wd_n;
      o_valid <= valid_n;
      o_data  <= data_n;
      o_sop   <= sop_n;
      o_end   <= end_n;
      o_ok    <= ok_n;
      busy    <= (state_n != S_IDLE);
      if (inc_good && cnt_good != '1) cnt_good <= cnt_good + 1'b1;
      if (inc_bad && cnt_bad != '1) cnt_bad <= cnt_bad + 1'b1;
    end
  end

endmodule

// File: tb/tb_lvds_rx_ctl.sv
// Directed bench for lvds_rx_ctl: vector table plus timeout and
// mid-frame reset sequences.
module tb_lvds_rx_ctl;

  logic        c = 1'b0;
  logic        rn = 1'b0;
  logic        ni_valid = 1'b0;
  logic [3:0]  ni = 4'h0;
  logic        ni_last = 1'b0;
  logic        o_valid, o_sop, o_end, o_ok, busy;
  logic [7:0]  o_data;
  logic [15:0] cnt_good, cnt_bad;

  lvds_rx_ctl #(.ADDR(8'h01), .TIMEOUT(64), .CW(16)) dut (
    .c(c), .rn(rn), .ni_valid(ni_valid), .ni(ni), .ni_last(ni_last),
    .o_valid(o_valid), .o_data(o_data), .o_sop(o_sop),
    .o_end(o_end), .o_ok(o_ok), .cnt_good(cnt_good),
    .cnt_bad(cnt_bad), .busy(busy)
  );

  always #5 c = ~c;

  typedef struct {
    logic       v;
    logic [3:0] n;
    logic       l;
    logic       ev;
    logic [7:0] ed;
    logic       es;
    logic       ee;
    logic       eo;
    int         g;
    int         b;
  } vec_t;

  vec_t tbl[$];
  int   eg = 0;
  int   eb = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [3:0] n, input logic l,
                     input logic ev, input logic [7:0] ed,
                     input logic es, input logic ee, input logic eo);
    vec_t t;
    t.v = v; t.n = n; t.l = l;
    t.ev = ev; t.ed = ed; t.es = es; t.ee = ee; t.eo = eo;
    t.g = eg; t.b = eb;
    tbl.push_back(t);
  endtask

  // frame: a, 02, A5, 3C, cr
  task automatic add_frame(input logic [7:0] a, input logic [7:0] cr,
                           input logic emit, input logic okv);
    logic [3:0] ns[10];
    ns = '{a[7:4], a[3:0], 4'h0, 4'h2, 4'hA, 4'h5,
           4'h3, 4'hC, cr[7:4], cr[3:0]};
    for (int i = 0; i < 10; i++) begin
      if (i == 9 && emit) begin
        if (okv) eg++;
        else eb++;
      end
      add(1'b1, ns[i], i == 9, emit && (i == 5 || i == 7),
          (i == 5) ? 8'hA5 : 8'h3C, emit && i == 5,
          emit && i == 9, emit && okv && i == 9);
    end
  endtask

  task automatic nib(input logic v, input logic [3:0] n, input logic l);
    @(negedge c);
    ni_valid = v;
    ni = n;
    ni_last = l;
    @(posedge c);
    #1;
  endtask

  task automatic send_good(input string tag);
    logic [3:0] ns[10];
    ns = '{4'h0, 4'h1, 4'h0, 4'h2, 4'hA, 4'h5, 4'h3, 4'hC, 4'h2, 4'hD};
    for (int i = 0; i < 10; i++) begin
      nib(1'b1, ns[i], i == 9);
      if (i == 5) begin
        chk({tag, " A5 valid"}, o_valid, 1);
        chk({tag, " A5 data"}, o_data, 8'hA5);
        chk({tag, " A5 sop"}, o_sop, 1);
      end
      if (i == 7) begin
        chk({tag, " 3C data"}, {o_valid, o_sop, o_data}, {2'b10, 8'h3C});
      end
      if (i == 9) chk({tag, " end/ok"}, {o_end, o_ok, o_valid}, 3'b110);
    end
  endtask

  int end_at, ends;
  logic ok_at;

  initial begin
    add_frame(8'h01, 8'h2D, 1'b1, 1'b1);
    add_frame(8'h01, 8'h2C, 1'b1, 1'b0);
    add_frame(8'h07, 8'h2D, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b0, 0, 8'h00, 0, 0, 0);
    add_frame(8'hFF, 8'hEA, 1'b1, 1'b1);
    add(1'b1, 4'h0, 1'b0, 0, 8'h00, 0, 0, 0);
    add(1'b1, 4'h1, 1'b0, 0, 8'h00, 0, 0, 0);
    add(1'b1, 4'h0, 1'b0, 0, 8'h00, 0, 0, 0);
    eb++;
    add(1'b1, 4'h0, 1'b0, 0, 8'h00, 0, 0, 0);
    add(1'b1, 4'h1, 1'b0, 0, 8'h00, 0, 0, 0);
    add(1'b1, 4'h2, 1'b1, 0, 8'h00, 0, 0, 0);
    add_frame(8'h01, 8'h2D, 1'b1, 1'b1);
    eb++;
    add(1'b1, 4'h0, 1'b1, 0, 8'h00, 0, 0, 0);
    add(1'b0, 4'h0, 1'b0, 0, 8'h00, 0, 0, 0);

    rn = 1'b0;
    repeat (3) @(posedge c);
    #1;
    chk("reset outs", {o_valid, o_sop, o_end, o_ok, busy, o_data}, 0);
    chk("reset cnts", {cnt_good, cnt_bad}, 0);
    @(negedge c);
    rn = 1'b1;

    foreach (tbl[i]) begin
      nib(tbl[i].v, tbl[i].n, tbl[i].l);
      chk($sformatf("row%0d o_valid", i), o_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("row%0d o_data", i), o_data, tbl[i].ed);
      chk($sformatf("row%0d o_sop", i), o_sop, tbl[i].es);
      chk($sformatf("row%0d o_end", i), o_end, tbl[i].ee);
      chk($sformatf("row%0d o_ok", i), o_ok, tbl[i].eo);
      chk($sformatf("row%0d cnt_good", i), cnt_good, tbl[i].g);
      chk($sformatf("row%0d cnt_bad", i), cnt_bad, tbl[i].b);
    end

    // watchdog: stall after first payload byte of a LEN=3 frame
    @(negedge c);
    rn = 1'b0;
    ni_valid = 1'b0;
    @(posedge c);
    #1;
    chk("rst2 cnts", {cnt_good, cnt_bad}, 0);
    @(negedge c);
    rn = 1'b1;
    nib(1, 4'h0, 0); nib(1, 4'h1, 0); nib(1, 4'h0, 0);
    nib(1, 4'h3, 0); nib(1, 4'hA, 0); nib(1, 4'h5, 0);
    chk("tmo A5", {o_valid, o_sop, o_data}, {2'b11, 8'hA5});
    chk("tmo busy", busy, 1);
    end_at = 0;
    ends = 0;
    ok_at = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      nib(0, 4'h0, 0);
      if (o_end) begin
        ends++;
        if (end_at == 0) begin
          end_at = k;
          ok_at = o_ok;
        end
      end
    end
    chk("tmo end cycle", end_at, 64);
    chk("tmo end count", ends, 1);
    chk("tmo ok", ok_at, 0);
    chk("tmo cnt_bad", cnt_bad, 1);
    chk("tmo cnt_good", cnt_good, 0);
    chk("tmo busy end", busy, 0);

    // reset in the middle of DATA
    nib(1, 4'h0, 0); nib(1, 4'h1, 0); nib(1, 4'h0, 0);
    nib(1, 4'h2, 0); nib(1, 4'hA, 0); nib(1, 4'h5, 0);
    chk("mid A5", o_valid, 1);
    @(negedge c);
    rn = 1'b0;
    ni_valid = 1'b0;
    @(posedge c);
    #1;
    chk("mid rst outs", {o_valid, o_sop, o_end, o_ok, busy, o_data}, 0);
    chk("mid rst cnts", {cnt_good, cnt_bad}, 0);
    @(negedge c);
    rn = 1'b1;
    send_good("post");
    chk("post cnt_good", cnt_good, 1);
    chk("post cnt_bad", cnt_bad, 0);
    nib(0, 4'h0, 0);
    chk("post idle", {o_valid, o_end, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
